// File: rtl/chunked_inc_dec_if.sv
// chunked_inc_dec_if
//   Handshake and data bundle for the chunked +/-1 unit.
//   master: requester side (drives start/mode/in_data, observes results).
//   slave : the unit itself (observes requests, drives ready/done/results).
// Signals:
//   start    request, accepted on an edge where ready=1
//   mode     0 = increment, 1 = decrement
//   in_data  operand
//   ready    unit can accept a request this cycle
//   done     one-cycle pulse, out_data/ovf/sovf valid
//   out_data result register
//   ovf      unsigned overflow
//   sovf     signed overflow
interface chunked_inc_dec_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] in_data;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] out_data;
  logic             ovf;
  logic             sovf;

  modport master (
    output start, mode, in_data,
    input  ready, done, out_data, ovf, sovf
  );

  modport slave (
    input  start, mode, in_data,
    output ready, done, out_data, ovf, sovf
  );
endinterface

// File: rtl/chunked_inc_dec.sv
// chunked_inc_dec
//   Multi-cycle +/-1 unit. The operand is walked CHUNK bits per clock,
//   least-significant chunk first, and the operation stops as soon as the
//   carry/borrow is absorbed. Result, ovf and sovf are registered and only
//   update on entry to DONE (or reset).
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset
//   bus  chunked_inc_dec_if slave modport (start/mode/in_data in,
//        ready/done/out_data/ovf/sovf out)
// States:
//   IDLE | waiting for start, ready=1
//   RUN  | processing chunk k, ready=0
//   DONE | one-cycle done pulse, ready=1, may accept a new start
module chunked_inc_dec #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic             clk,
  input logic             rst,
  chunked_inc_dec_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [WIDTH-1:0] operand, operand_nxt;
  logic [WIDTH-1:0] out_q, out_nxt;
  logic             mode_q, mode_nxt;
  logic             carry, carry_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic             ovf_q, ovf_nxt;
  logic             sovf_q, sovf_nxt;
  logic             ready_q, done_q;

  logic [CHUNK-1:0] chunk;
  logic [CHUNK-1:0] chunk_sum;
  logic             carry_out;

  // Chunk k datapath: a single CHUNK-bit +/-1, independent of WIDTH.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (k == KW'(i)) chunk = work[i*CHUNK +: CHUNK];
    end
    chunk_sum = mode_q ? (chunk - CHUNK'(carry)) : (chunk + CHUNK'(carry));
    // Carry survives only through an all-ones chunk (inc) or zero chunk (dec).
    carry_out = carry & (mode_q ? (chunk == '0) : (chunk == '1));
  end

  always_comb begin
    state_nxt   = state;
    work_nxt    = work;
    operand_nxt = operand;
    mode_nxt    = mode_q;
    carry_nxt   = carry;
    k_nxt       = k;
    out_nxt     = out_q;
    ovf_nxt     = ovf_q;
    sovf_nxt    = sovf_q;

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (bus.start) begin
          state_nxt   = RUN;
          work_nxt    = bus.in_data;
          operand_nxt = bus.in_data;
          mode_nxt    = bus.mode;
          carry_nxt   = 1'b1;
          k_nxt       = '0;
        end
      end

      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (k == KW'(i)) work_nxt[i*CHUNK +: CHUNK] = chunk_sum;
        end
        carry_nxt = carry_out;
        if (!carry_out || (k == K_LAST)) begin
          state_nxt = DONE;
          // carry_out can only still be set here when the top chunk wrapped.
          ovf_nxt   = carry_out;
          sovf_nxt  = mode_q ? ( operand[WIDTH-1] & ~work_nxt[WIDTH-1])
                             : (~operand[WIDTH-1] &  work_nxt[WIDTH-1]);
          // On overflow the operand is already the clamp value
          // (all-ones for inc, zero for dec).
          out_nxt   = (SATURATE && carry_out) ? operand : work_nxt;
        end else begin
          k_nxt = k + KW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      operand <= '0;
      mode_q  <= 1'b0;
      carry   <= 1'b0;
      k       <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      sovf_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      work    <= work_nxt;
      operand <= operand_nxt;
      mode_q  <= mode_nxt;
      carry   <= carry_nxt;
      k       <= k_nxt;
      out_q   <= out_nxt;
      ovf_q   <= ovf_nxt;
      sovf_q  <= sovf_nxt;
      ready_q <= (state_nxt != RUN);
      done_q  <= (state_nxt == DONE);
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.out_data = out_q;
  assign bus.ovf      = ovf_q;
  assign bus.sovf     = sovf_q;

endmodule

// File: tb/tb_chunked_inc_dec.sv
// tb_chunked_inc_dec
//   Directed bench for chunked_inc_dec. Three instances share clk/rst:
//   a: WIDTH=16 CHUNK=4 wrap, b: WIDTH=16 CHUNK=4 saturate,
//   c: WIDTH=8 CHUNK=8 wrap. Expected values are hand-computed constants.
module tb_chunked_inc_dec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  chunked_inc_dec_if #(.WIDTH(16)) a_bus ();
  chunked_inc_dec_if #(.WIDTH(16)) b_bus ();
  chunked_inc_dec_if #(.WIDTH(8))  c_bus ();

  chunked_inc_dec #(.WIDTH(16), .CHUNK(4), .SATURATE(1'b0)) u_a (
    .clk (clk), .rst (rst), .bus (a_bus)
  );
  chunked_inc_dec #(.WIDTH(16), .CHUNK(4), .SATURATE(1'b1)) u_b (
    .clk (clk), .rst (rst), .bus (b_bus)
  );
  chunked_inc_dec #(.WIDTH(8), .CHUNK(8), .SATURATE(1'b0)) u_c (
    .clk (clk), .rst (rst), .bus (c_bus)
  );

  task automatic check_v(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_b(input string tag, input logic observed,
                         input logic expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic m,
                       input logic [15:0] d);
    case (sel)
      0:       begin a_bus.start = st; a_bus.mode = m; a_bus.in_data = d; end
      1:       begin b_bus.start = st; b_bus.mode = m; b_bus.in_data = d; end
      default: begin c_bus.start = st; c_bus.mode = m; c_bus.in_data = d[7:0]; end
    endcase
  endtask

  // {ready, done, ovf, sovf, out_data[15:0]}
  function automatic logic [19:0] obs(input int sel);
    case (sel)
      0:       obs = {a_bus.ready, a_bus.done, a_bus.ovf, a_bus.sovf, a_bus.out_data};
      1:       obs = {b_bus.ready, b_bus.done, b_bus.ovf, b_bus.sovf, b_bus.out_data};
      default: obs = {c_bus.ready, c_bus.done, c_bus.ovf, c_bus.sovf, 8'h00, c_bus.out_data};
    endcase
  endfunction

  // Called #1 after the accept edge; counts edges until done is seen.
  task automatic wait_done(input int sel, output int cyc);
    cyc = 0;
    while (obs(sel)[18] !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Issue one operation (caller is #1 after an edge with ready=1) and check
  // latency and results in the done cycle.
  task automatic op(input int sel, input string name, input logic m,
                    input logic [15:0] d, input logic [15:0] exp_q,
                    input logic exp_ovf, input logic exp_sovf, input int exp_cyc);
    int cyc;
    logic [19:0] o;
    drive(sel, 1'b1, m, d);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, m, d);
    wait_done(sel, cyc);
    o = obs(sel);
    check_v({name, "/latency"},  16'(cyc), 16'(exp_cyc));
    check_v({name, "/out_data"}, o[15:0], exp_q);
    check_b({name, "/ovf"},      o[17], exp_ovf);
    check_b({name, "/sovf"},     o[16], exp_sovf);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pulses;
    logic [19:0] o;

    drive(0, 1'b0, 1'b0, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000);
    drive(2, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    o = obs(0);
    check_b("a_reset/ready", o[19], 1'b1);
    check_b("a_reset/done",  o[18], 1'b0);
    check_v("a_reset/out",   o[15:0], 16'h0000);
    check_b("a_reset/ovf",   o[17], 1'b0);
    o = obs(2);
    check_b("c_reset/ready", o[19], 1'b1);
    check_v("c_reset/out",   o[15:0], 16'h0000);

    // 16/4 wrap instance
    op(0, "a_inc_0000", 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1);
    @(posedge clk);
    #1;
    o = obs(0);
    check_b("a_pulse/done_one_cycle", o[18], 1'b0);
    check_b("a_pulse/ready_idle",     o[19], 1'b1);
    check_v("a_pulse/out_held",       o[15:0], 16'h0001);

    op(0, "a_inc_00FF", 1'b0, 16'h00FF, 16'h0100, 1'b0, 1'b0, 3);
    op(0, "a_inc_7FFF", 1'b0, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 4);
    op(0, "a_dec_8000", 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 4);
    op(0, "a_dec_1230", 1'b1, 16'h1230, 16'h122F, 1'b0, 1'b0, 2);

    // Handshake: start held through RUN with a different operand is ignored.
    drive(0, 1'b1, 1'b0, 16'h00FF);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b1, 16'h0F00);
    wait_done(0, cyc);
    o = obs(0);
    check_v("hs_ignore/latency",  16'(cyc), 16'd3);
    check_v("hs_ignore/out_data", o[15:0], 16'h0100);
    check_b("hs_ignore/ready",    o[19], 1'b1);
    // Start during DONE is accepted directly.
    op(0, "hs_b2b_inc_0001", 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1);

    op(0, "a_inc_FFFF", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 4);
    op(0, "a_dec_0000", 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 4);

    // 16/4 saturating instance
    op(1, "b_inc_FFFF", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4);
    op(1, "b_dec_0000", 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 4);
    op(1, "b_inc_00FF", 1'b0, 16'h00FF, 16'h0100, 1'b0, 1'b0, 3);
    op(1, "b_dec_8000", 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 4);

    // 8/8 instance: every operation is a single chunk
    op(2, "c_inc_FF", 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1);
    op(2, "c_dec_80", 1'b1, 16'h0080, 16'h007F, 1'b0, 1'b1, 1);
    op(2, "c_inc_7F", 1'b0, 16'h007F, 16'h0080, 1'b0, 1'b1, 1);
    op(2, "c_dec_00", 1'b1, 16'h0000, 16'h00FF, 1'b1, 1'b0, 1);
    op(2, "c_inc_41", 1'b0, 16'h0041, 16'h0042, 1'b0, 1'b0, 1);

    // Reset mid-RUN on instance a (last result 0xFFFF with ovf=1)
    @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 16'hFFFF);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 16'hFFFF);
    @(posedge clk);
    #1;
    o = obs(0);
    check_b("rst_mid/ready_in_run", o[19], 1'b0);
    check_v("rst_mid/out_held",     o[15:0], 16'hFFFF);
    check_b("rst_mid/ovf_held",     o[17], 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    o = obs(0);
    check_b("rst_mid/ready", o[19], 1'b1);
    check_b("rst_mid/done",  o[18], 1'b0);
    check_v("rst_mid/out",   o[15:0], 16'h0000);
    check_b("rst_mid/ovf",   o[17], 1'b0);
    check_b("rst_mid/sovf",  o[16], 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (obs(0)[18] === 1'b1) pulses++;
    end
    check_v("rst_mid/no_done_after", 16'(pulses), 16'd0);
    check_b("rst_mid/ready_after",   obs(0)[19], 1'b1);

    // Operation after reset works normally
    op(0, "a_post_rst_inc_000F", 1'b0, 16'h000F, 16'h0010, 1'b0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
